// File: rtl/watch_pkg.sv
// Shared types for the watch front-end controller: mode ring, edited
// field, button priority order and the two controller states.
package watch_pkg;

  localparam int NUM_MODES = 7;
  localparam int NUM_BTNS  = 6;

  typedef enum logic [2:0] {
    MODE_DATE      = 3'd0,
    MODE_WATCH     = 3'd1,
    MODE_ALARM     = 3'd2,
    MODE_STOPWATCH = 3'd3,
    MODE_TIMER     = 3'd4,
    MODE_DDAY      = 3'd5,
    MODE_LADDER    = 3'd6
  } mode_t;

  typedef enum logic [1:0] {
    FIELD_LO  = 2'd0,
    FIELD_MID = 2'd1,
    FIELD_HI  = 2'd2
  } field_t;

  // Lower index means higher priority when several presses coincide.
  typedef enum logic [2:0] {
    BTN_ESC   = 3'd0,
    BTN_ENTER = 3'd1,
    BTN_UP    = 3'd2,
    BTN_DOWN  = 3'd3,
    BTN_LEFT  = 3'd4,
    BTN_RIGHT = 3'd5,
    BTN_NONE  = 3'd6
  } btn_t;

  typedef enum logic {
    ST_NAV  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  // Highest-priority press in the vector, or BTN_NONE.
  function automatic btn_t pick_btn(input logic [NUM_BTNS-1:0] p);
    btn_t r;
    r = BTN_NONE;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (p[i]) r = btn_t'(3'(i));
    end
    return r;
  endfunction

  function automatic field_t field_left(input field_t f);
    case (f)
      FIELD_LO:  return FIELD_MID;
      FIELD_MID: return FIELD_HI;
      default:   return FIELD_LO;
    endcase
  endfunction

  function automatic field_t field_right(input field_t f);
    case (f)
      FIELD_HI:  return FIELD_MID;
      FIELD_MID: return FIELD_LO;
      default:   return FIELD_HI;
    endcase
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: two-flop synchronizer on an active-low raw input,
// debounce on the inverted level, one-cycle pulse on accepted press.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          sample;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    sync1_d = btn_n_i;
    sync2_d = sync1_q;
    sample  = ~sync2_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sample != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d   = sample;
        press_d = sample;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer resets to the released (high) raw level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = deb_q;
  assign press_o = press_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch display front-end: conditions six buttons, runs the mode ring and
// the date/watch edit state, issues inc/dec strobes and the blink mask.
// Optional hold-to-repeat in edit: WATCH_MODE_CTRL_AUTO_REPEAT_EN.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int BLINK_HALF      = 500000,
  parameter int EDIT_TIMEOUT    = 30000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       enter_i,
  input  logic       esc_i,
  output logic [2:0] mode,
  output logic       edit,
  output logic [1:0] field,
  output logic       inc_o,
  output logic       dec_o,
  output logic [5:0] digit_en
);

  localparam int REPEAT_DELAY  = 8 * BLINK_HALF;
  localparam int REPEAT_PERIOD = BLINK_HALF;
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int IW = $clog2(EDIT_TIMEOUT + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(EDIT_TIMEOUT - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
`ifdef WATCH_MODE_CTRL_AUTO_REPEAT_EN
  localparam logic REPEAT_EN = 1'b1;
`else
  localparam logic REPEAT_EN = 1'b0;
`endif

  logic [NUM_BTNS-1:0] raw_n, press, level;
  logic                unused_levels;

  assign raw_n = {right_i, left_i, down_i, up_i, enter_i, esc_i};
  // Only up/down levels matter (hold-to-repeat); the rest are sinks.
  assign unused_levels = ^{level[BTN_ESC], level[BTN_ENTER], level[BTN_LEFT], level[BTN_RIGHT]};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (raw_n[g]),
      .level_o (level[g]),
      .press_o (press[g])
    );
  end

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  field_t        field_q, field_d;
  logic          inc_q, inc_d, dec_q, dec_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          rep_on_q, rep_on_d, rep_dn_q, rep_dn_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  btn_t          act;
  logic          any_press, rep_held, rep_fire;

  assign act       = pick_btn(press);
  assign any_press = |press;
  assign rep_held  = rep_dn_q ? level[BTN_DOWN] : level[BTN_UP];
  assign rep_fire  = REPEAT_EN && rep_on_q && rep_held && (rep_cnt_q == REP_LAST);

  // Next-state: the single highest-priority press acts, then repeat, then timeout.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    field_d     = field_q;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    idle_d      = '0;
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
    phase_d     = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
    rep_on_d    = rep_on_q;
    rep_dn_d    = rep_dn_q;
    rep_cnt_d   = rep_cnt_q;
    if (rep_on_q) begin
      if (rep_held) rep_cnt_d = (rep_cnt_q == REP_LAST) ? REP_RELOAD : rep_cnt_q + RW'(1);
      else          rep_on_d  = 1'b0;
    end
    case (state_q)
      ST_NAV: begin
        rep_on_d = 1'b0;
        case (act)
          BTN_UP:   mode_d = (mode_q == mode_t'(NUM_MODES - 1)) ? MODE_DATE
                                                                : mode_t'(3'(mode_q) + 3'd1);
          BTN_DOWN: mode_d = (mode_q == MODE_DATE) ? mode_t'(NUM_MODES - 1)
                                                   : mode_t'(3'(mode_q) - 3'd1);
          BTN_ENTER: begin
            if (mode_q == MODE_DATE || mode_q == MODE_WATCH) begin
              state_d     = ST_EDIT;
              field_d     = FIELD_HI;
              blink_cnt_d = '0;
              phase_d     = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_EDIT: begin
        if (any_press) begin
          rep_on_d = 1'b0;
          case (act)
            BTN_ESC: begin
              state_d = ST_NAV;
              field_d = FIELD_HI;
            end
            BTN_UP: begin
              inc_d = 1'b1; rep_on_d = 1'b1; rep_dn_d = 1'b0; rep_cnt_d = '0;
            end
            BTN_DOWN: begin
              dec_d = 1'b1; rep_on_d = 1'b1; rep_dn_d = 1'b1; rep_cnt_d = '0;
            end
            BTN_LEFT:  field_d = field_left(field_q);
            BTN_RIGHT: field_d = field_right(field_q);
            default: ;
          endcase
        end else if (rep_fire) begin
          inc_d = ~rep_dn_q;
          dec_d = rep_dn_q;
        end else if (idle_q == IDLE_LAST) begin
          state_d  = ST_NAV;
          field_d  = FIELD_HI;
          rep_on_d = 1'b0;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      default: state_d = ST_NAV;
    endcase
  end

  // Controller state register; reset aborts any edit in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_NAV;
      mode_q      <= MODE_WATCH;
      field_q     <= FIELD_HI;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      idle_q      <= '0;
      rep_on_q    <= 1'b0;
      rep_dn_q    <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      field_q     <= field_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      idle_q      <= idle_d;
      rep_on_q    <= rep_on_d;
      rep_dn_q    <= rep_dn_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  // Blink mask: only the edited digit pair follows the blink phase.
  always_comb begin
    digit_en = 6'b111111;
    if (state_q == ST_EDIT) begin
      case (field_q)
        FIELD_LO:  digit_en[1:0] = {2{phase_q}};
        FIELD_MID: digit_en[3:2] = {2{phase_q}};
        default:   digit_en[5:4] = {2{phase_q}};
      endcase
    end
  end

  assign mode  = mode_q;
  assign edit  = (state_q == ST_EDIT);
  assign field = field_q;
  assign inc_o = inc_q;
  assign dec_o = dec_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: directed scenarios plus random
// button activity, compared every cycle against a behavioural model.
module tb_watch_mode_ctrl;

  localparam int DB = 4;
  localparam int BH = 8;
  localparam int ET = 100;
`ifdef WATCH_MODE_CTRL_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  // Button bit order: 0 esc, 1 enter, 2 up, 3 down, 4 left, 5 right.
  localparam logic [5:0] B_ESC = 6'h01, B_ENT = 6'h02, B_UP = 6'h04;
  localparam logic [5:0] B_DN = 6'h08, B_LF = 6'h10, B_RT = 6'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] btn_n = 6'h3F;
  logic [2:0] mode;
  logic       edit;
  logic [1:0] field;
  logic       inc_o, dec_o;
  logic [5:0] digit_en;

  watch_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_HALF(BH), .EDIT_TIMEOUT(ET)) dut (
    .clk(clk), .rst(rst),
    .up_i(btn_n[2]), .down_i(btn_n[3]), .left_i(btn_n[4]), .right_i(btn_n[5]),
    .enter_i(btn_n[1]), .esc_i(btn_n[0]),
    .mode(mode), .edit(edit), .field(field), .inc_o(inc_o), .dec_o(dec_o),
    .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int tick_no = 0, cnt_inc = 0, t1 = 0, t2 = 0, edit_cycles = 0;

  // Behavioural model state.
  int         m_mode = 1, m_field = 2, m_since = 0, m_idle = 0;
  bit         m_edit = 0, m_inc = 0, m_dec = 0;
  bit         rep_on = 0;
  int         rep_btn = 2, rep_hold = 0;
  logic [5:0] rq[$];
  logic [5:0] acc = 6'h00, pend = 6'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, tick_no);
    end
  endtask

  function automatic logic [5:0] exp_digits();
    logic [5:0] d;
    logic       ph;
    d = 6'h3F;
    if (m_edit) begin
      ph = ((m_since / BH) % 2) == 0;
      d[2*m_field]   = ph;
      d[2*m_field+1] = ph;
    end
    return d;
  endfunction

  // One clock of the model: act on last cycle's press, then debounce.
  task automatic model_step();
    int  top;
    bit  fire;
    bit  all_eq;
    if (rst) begin
      m_mode = 1; m_edit = 0; m_field = 2; m_inc = 0; m_dec = 0;
      m_since = 0; m_idle = 0; rep_on = 0;
      rq = {};
      for (int i = 0; i < DB + 4; i++) rq.push_back(6'h3F);
      acc = 6'h00; pend = 6'h00;
      return;
    end
    m_inc = 0; m_dec = 0; m_since++;
    top = -1;
    for (int b = 0; b < 6; b++) if (pend[b] && top < 0) top = b;
    if (!m_edit) begin
      rep_on = 0;
      case (top)
        2: m_mode = (m_mode + 1) % 7;
        3: m_mode = (m_mode + 6) % 7;
        1: if (m_mode <= 1) begin m_edit = 1; m_field = 2; m_since = 0; m_idle = 0; end
        default: ;
      endcase
    end else if (top >= 0) begin
      m_idle = 0; rep_on = 0;
      case (top)
        0: begin m_edit = 0; m_field = 2; end
        2: begin m_inc = 1; rep_on = 1; rep_btn = 2; rep_hold = 0; end
        3: begin m_dec = 1; rep_on = 1; rep_btn = 3; rep_hold = 0; end
        4: m_field = (m_field + 1) % 3;
        5: m_field = (m_field + 2) % 3;
        default: ;
      endcase
    end else begin
      fire = 0;
      if (rep_on) begin
        if (acc[rep_btn]) begin
          rep_hold++;
          if (REP && rep_hold >= 8*BH && (rep_hold - 8*BH) % BH == 0) fire = 1;
        end else rep_on = 0;
      end
      if (fire) begin
        m_idle = 0;
        if (rep_btn == 2) m_inc = 1; else m_dec = 1;
      end else begin
        m_idle++;
        if (m_idle == ET) begin m_edit = 0; m_field = 2; rep_on = 0; end
      end
    end
    // Level seen by the debouncer at this edge is the raw sample from two edges ago.
    rq.push_front(btn_n);
    while (rq.size() > DB + 4) void'(rq.pop_back());
    pend = 6'h00;
    for (int b = 0; b < 6; b++) begin
      all_eq = 1;
      for (int k = 1; k < DB; k++) if (rq[2+k][b] != rq[2][b]) all_eq = 0;
      if (all_eq && (~rq[2][b]) != acc[b]) begin
        acc[b]  = ~rq[2][b];
        pend[b] = ~rq[2][b];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    tick_no++;
    if (inc_o === 1'b1) begin
      cnt_inc++;
      if (cnt_inc == 1) t1 = tick_no;
      if (cnt_inc == 2) t2 = tick_no;
    end
    if (edit === 1'b1) edit_cycles++;
    chk("mode", 32'(mode), 32'(m_mode));
    chk("edit", 32'(edit), 32'(m_edit));
    chk("inc", 32'(inc_o), 32'(m_inc));
    chk("dec", 32'(dec_o), 32'(m_dec));
    chk("digit_en", 32'(digit_en), 32'(exp_digits()));
    chk("inc_dec_excl", 32'(inc_o & dec_o), 32'd0);
    if (m_edit) chk("field", 32'(field), 32'(m_field));
  endtask

  task automatic press(input logic [5:0] mask, input int hold, input int gap);
    btn_n = 6'h3F & ~mask;
    repeat (hold) tick();
    btn_n = 6'h3F;
    repeat (gap) tick();
  endtask

  initial begin
    int lat;
    int gap;
    logic [5:0] m;
    rst = 1'b1;
    btn_n = 6'h3F;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_mode", 32'(mode), 32'd1);
    chk("rst_edit", 32'(edit), 32'd0);
    chk("rst_field", 32'(field), 32'd2);
    chk("rst_digits", 32'(digit_en), 32'h3F);

    // Mode ring forward and backward wrap.
    for (int i = 0; i < 7; i++) begin
      press(B_UP, 6, 8);
      chk("ring_up", 32'(mode), 32'((i + 2) % 7));
    end
    press(B_DN, 6, 8);
    chk("ring_down_wrap", 32'(mode), 32'd0);
    press(B_UP, 6, 8);

    // Short glitch rejected; long hold advances once with fixed latency.
    press(B_UP, 3, 10);
    chk("glitch", 32'(mode), 32'd1);
    lat = 0;
    btn_n = ~B_UP;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (lat == 0 && mode !== 3'd1) lat = k;
    end
    btn_n = 6'h3F;
    repeat (10) tick();
    chk("latency", 32'(lat), 32'd7);
    chk("one_advance", 32'(mode), 32'd2);
    press(B_DN, 6, 8);

    // Enter edit, blink phase, field selection.
    btn_n = ~B_ENT;
    repeat (7) tick();
    chk("enter_edit", 32'(edit), 32'd1);
    chk("enter_field", 32'(field), 32'd2);
    chk("blink_on", 32'(digit_en), 32'h3F);
    btn_n = 6'h3F;
    repeat (8) tick();
    chk("blink_off", 32'(digit_en), 32'h0F);
    press(B_LF, 6, 8);
    chk("left_wrap", 32'(field), 32'd0);
    press(B_RT, 6, 8);
    press(B_RT, 6, 8);
    chk("right_twice", 32'(field), 32'd1);
    cnt_inc = 0;
    press(B_UP, 6, 8);
    chk("inc_once", 32'(cnt_inc), 32'd1);
    chk("edit_mode_kept", 32'(mode), 32'd1);
    press(B_ESC, 6, 8);
    chk("esc_exit", 32'(edit), 32'd0);
    chk("esc_digits", 32'(digit_en), 32'h3F);
    chk("esc_field", 32'(field), 32'd2);

    // Simultaneous esc+enter in edit: esc wins.
    press(B_ENT, 6, 8);
    press(B_ESC | B_ENT, 6, 8);
    chk("esc_priority", 32'(edit), 32'd0);

    // Enter ignored outside date/watch.
    press(B_UP, 6, 8);
    press(B_UP, 6, 8);
    press(B_ENT, 6, 8);
    chk("enter_mode3", 32'(edit), 32'd0);
    press(B_DN, 6, 8);
    press(B_DN, 6, 8);

    // Idle timeout.
    edit_cycles = 0;
    press(B_ENT, 6, 8);
    repeat (120) tick();
    chk("timeout_len", 32'(edit_cycles), 32'(ET));

    // Reset in the middle of edit and of a debounce.
    press(B_ENT, 6, 8);
    btn_n = ~B_UP;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    btn_n = 6'h3F;
    chk("rst_mid_mode", 32'(mode), 32'd1);
    chk("rst_mid_edit", 32'(edit), 32'd0);
    tick();
    chk("post_rst_inc", 32'(inc_o), 32'd0);
    chk("post_rst_dec", 32'(dec_o), 32'd0);
    repeat (10) tick();

    // Long hold in edit: single strobe, or repeats when auto-repeat is built in.
    press(B_ENT, 6, 8);
    cnt_inc = 0; t1 = 0; t2 = 0;
    press(B_UP, 200, 12);
    chk("hold_strobes", 32'(cnt_inc), REP ? 32'd18 : 32'd1);
    gap = (cnt_inc > 1) ? t2 - t1 : 0;
    chk("repeat_delay", 32'(gap), REP ? 32'd64 : 32'd0);
    press(B_ESC, 6, 8);

    // Random activity against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          rst = 1'b1;
          repeat ($urandom_range(1, 2)) tick();
          rst = 1'b0;
        end
        1: press(6'(1 << $urandom_range(0, 5)), $urandom_range(1, 3), $urandom_range(1, 6));
        2: begin
          m = 6'(1 << $urandom_range(0, 5)) | 6'(1 << $urandom_range(0, 5));
          press(m, $urandom_range(4, 10), $urandom_range(6, 10));
        end
        3: press($urandom_range(0, 1) ? B_UP : B_DN, $urandom_range(60, 110), $urandom_range(6, 10));
        4: repeat ($urandom_range(0, 120)) tick();
        default: press(6'(1 << $urandom_range(0, 5)), $urandom_range(4, 12), $urandom_range(5, 10));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
